fetch_unit: RTL

Instruction fetch stage. It produces the instruction word that control_unit decodes and consumes control_unit's pc_src encoding (00=PC+4, 01=branch, 10=jump) to steer the PC. It issues word requests to instruction memory over a valid/ready request channel with an in-order response channel. Fetched words are buffered in a small FIFO and handed downstream with a valid/ready handshake. Opcode, funct3 and funct7 are pre-sliced for direct connection to control_unit.

---
 rtl/core_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 77 +++++++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: PC-select encoding used by control_unit and the
// fetch stage, RV32 major opcodes and fetch FSM states.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'b00,
        FS_RUN   = 2'b01,
        FS_FLUSH = 2'b10
    } fetch_state_e;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    // Only jumps and taken branches steer the PC; reserved encoding is ignored.
    function automatic logic is_taken_redirect(input logic       valid,
                                               input logic [1:0] src,
                                               input logic       taken);
        logic result;
        case (src)
            PC_JUMP:   result = valid;
            PC_BRANCH: result = valid & taken;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with single-cycle flush; head word is visible
// combinationally on rdata whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags and qualified push/pop; a push on a full FIFO needs a pop.
    always_comb begin
        full_s    = (count_r == CNT_MAX);
        empty_s   = (count_r == {(AW+1){1'b0}});
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
        full      = full_s;
        empty     = empty_s;
        count     = count_r;
        rdata     = mem_r[rd_ptr_r];
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests to instruction memory,
// buffered show-ahead delivery, and redirect handling with stale-response drop.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        misalign_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);

    fetch_state_e    state_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] rsp_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   drop_cnt_r;
    logic            misalign_r;

    logic            taken_s;
    logic [XLEN-1:0] target_s;
    logic            rsp_s;
    logic [CW:0]     credit_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            instr_valid_s;
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   outstanding_dec_s;
    logic [CW-1:0]   outstanding_next_s;
    logic [CW-1:0]   drop_dec_s;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic [63:0]     head_s;
    logic [31:0]     head_instr_s;
    logic [31:0]     head_pc_s;

    // Handshake qualification and next-value arithmetic for the counters.
    always_comb begin
        taken_s       = is_taken_redirect(redirect_valid, pc_src, branch_taken);
        target_s      = {redirect_target[XLEN-1:2], 2'b00};
        rsp_s         = imem_rsp_valid && (outstanding_r != CNT_ZERO);
        credit_s      = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
        req_valid_s   = (state_r == FS_RUN) && (credit_s < DEPTH_W) && !taken_s;
        req_fire_s    = req_valid_s && imem_req_ready;
        instr_valid_s = !fifo_empty_s && !taken_s;
        pop_s         = instr_valid_s && instr_ready;
        push_s        = rsp_s && (drop_cnt_r == CNT_ZERO) && !taken_s &&
                        (!fifo_full_s || pop_s);
        if (rsp_s) begin
            outstanding_dec_s = outstanding_r - CNT_ONE;
        end else begin
            outstanding_dec_s = outstanding_r;
        end
        if (req_fire_s) begin
            outstanding_next_s = outstanding_dec_s + CNT_ONE;
        end else begin
            outstanding_next_s = outstanding_dec_s;
        end
        if (rsp_s && (drop_cnt_r != CNT_ZERO)) begin
            drop_dec_s = drop_cnt_r - CNT_ONE;
        end else begin
            drop_dec_s = drop_cnt_r;
        end
    end

    // Fetch FSM with PC, in-flight and drop bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FS_IDLE;
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            drop_cnt_r    <= CNT_ZERO;
            misalign_r    <= 1'b0;
        end else begin
            misalign_r    <= taken_s && (redirect_target[1:0] != 2'b00);
            outstanding_r <= outstanding_next_s;
            if (taken_s) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc_r <= target_s;
                rsp_pc_r   <= target_s;
                drop_cnt_r <= outstanding_dec_s;
                state_r    <= (outstanding_dec_s != CNT_ZERO) ? FS_FLUSH : FS_RUN;
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + 32'd4;
                end
                drop_cnt_r <= drop_dec_s;
                case (state_r)
                    FS_IDLE:  state_r <= FS_RUN;
                    FS_RUN:   state_r <= FS_RUN;
                    FS_FLUSH: state_r <= (drop_dec_s == CNT_ZERO) ? FS_RUN : FS_FLUSH;
                    default:  state_r <= FS_IDLE;
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (taken_s),
        .wdata ({rsp_pc_r, imem_rsp_data}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Output drive; an empty FIFO presents all-zero instruction fields.
    always_comb begin
        if (fifo_empty_s) begin
            head_instr_s = 32'h0000_0000;
            head_pc_s    = 32'h0000_0000;
        end else begin
            head_instr_s = head_s[31:0];
            head_pc_s    = head_s[63:32];
        end
        imem_req_valid = req_valid_s;
        imem_req_addr  = fetch_pc_r;
        instr_valid    = instr_valid_s;
        instr          = head_instr_s;
        instr_pc       = head_pc_s;
        opcode         = head_instr_s[6:0];
        funct3         = head_instr_s[14:12];
        funct7         = head_instr_s[31:25];
        misalign_err   = misalign_r;
    end

endmodule
